// File: rtl/mvm_host_pkg.sv
// Shared types and default sizing for the mvm engine host driver.
package mvm_host_pkg;

  localparam int K_DEF       = 16;
  localparam int B_DEF       = 8;
  localparam int TIMEOUT_DEF = 1024;

  localparam int LOG_BUF_DEF = $clog2(K_DEF * K_DEF);
  localparam int LOG_K_DEF   = $clog2(K_DEF) + 1;
  localparam int Y_W_DEF     = 2 * B_DEF;

  typedef enum logic [3:0] {
    FILL_A,
    LOAD_A,
    SEND_A,
    FILL_X,
    LOAD_X,
    SEND_X,
    START,
    WAIT_DONE,
    CAPTURE,
    DRAIN
  } mvm_host_state_t;

endpackage

// File: rtl/mvm_host_if.sv
// Host-side job input stream and result output stream of the mvm driver.
interface mvm_host_if #(
  parameter int B = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [B-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [2*B-1:0] out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mvm_host_buf.sv
// Single-port staging RAM with write enable and registered read.
module mvm_host_buf #(
  parameter int B     = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic signed [B-1:0] wdata,
  output logic signed [B-1:0] rdata
);

  logic signed [B-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mvm_host_driver.sv
// Host sequencer for the mvm engine: stages a job, replays it as load bursts,
// starts the engine and streams the captured results out.
module mvm_host_driver
  import mvm_host_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int B       = B_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int LOG_BUF = $clog2(K * K),
  parameter int LOG_K   = $clog2(K) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mvm_host_if.slave             host,
  output logic                  err,
  output logic                  mvm_load_matrix,
  output logic                  mvm_load_vector,
  output logic                  mvm_start,
  output logic signed [B-1:0]   mvm_data,
  input  logic                  mvm_done,
  input  logic signed [2*B-1:0] mvm_y
);

  localparam int WD_W  = $clog2(TIMEOUT) + 1;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  localparam logic [LOG_BUF-1:0] LAST_A  = LOG_BUF'(K * K - 1);
  localparam logic [LOG_BUF-1:0] LAST_X  = LOG_BUF'(K - 1);
  localparam logic [LOG_K-1:0]   LAST_Y  = LOG_K'(K - 1);
  localparam logic [WD_W-1:0]    LAST_WD = WD_W'(TIMEOUT - 1);

  mvm_host_state_t state, state_nx;
  logic                  active;
  logic [LOG_BUF-1:0]    n, n_nx;
  logic [LOG_K-1:0]      m, m_nx;
  logic [WD_W-1:0]       wd, wd_nx;
  logic                  err_nx;
  logic                  in_fire;
  logic                  buf_we;
  logic                  cap_en;
  logic [LOG_BUF-1:0]    buf_addr;
  logic signed [B-1:0]   buf_rdata;
  logic [IDX_W-1:0]      m_idx;
  logic signed [2*B-1:0] r [K];

  assign m_idx = m[IDX_W-1:0];

  // active holds in_ready low for the first cycle after reset releases
  assign host.in_ready   = active && (state == FILL_A || state == FILL_X);
  assign host.out_valid  = (state == DRAIN);
  assign host.out_data   = (state == DRAIN) ? r[m_idx] : '0;
  assign host.out_last   = (state == DRAIN) && (m == LAST_Y);
  assign mvm_load_matrix = (state == LOAD_A);
  assign mvm_load_vector = (state == LOAD_X);
  assign mvm_start       = (state == START);
  assign mvm_data        = (state == SEND_A || state == SEND_X) ? buf_rdata : '0;
  assign in_fire         = host.in_valid && host.in_ready;

  always_comb begin
    state_nx = state;
    n_nx     = n;
    m_nx     = m;
    wd_nx    = wd;
    err_nx   = err;
    buf_we   = 1'b0;
    buf_addr = n;
    cap_en   = 1'b0;
    unique case (state)
      FILL_A: begin
        if (in_fire) begin
          buf_we = 1'b1;
          if (n == LAST_A) begin
            n_nx     = '0;
            state_nx = LOAD_A;
          end else begin
            n_nx = n + 1'b1;
          end
        end
      end
      LOAD_A: begin
        buf_addr = '0;
        state_nx = SEND_A;
      end
      // read address runs one ahead of mvm_data to keep the burst gapless
      SEND_A: begin
        buf_addr = n + 1'b1;
        if (n == LAST_A) begin
          n_nx     = '0;
          state_nx = FILL_X;
        end else begin
          n_nx = n + 1'b1;
        end
      end
      FILL_X: begin
        if (in_fire) begin
          buf_we = 1'b1;
          if (n == LAST_X) begin
            n_nx     = '0;
            state_nx = LOAD_X;
          end else begin
            n_nx = n + 1'b1;
          end
        end
      end
      LOAD_X: begin
        buf_addr = '0;
        state_nx = SEND_X;
      end
      SEND_X: begin
        buf_addr = n + 1'b1;
        if (n == LAST_X) begin
          n_nx     = '0;
          state_nx = START;
        end else begin
          n_nx = n + 1'b1;
        end
      end
      START: begin
        wd_nx    = '0;
        state_nx = WAIT_DONE;
      end
      // done is checked first so it wins on the expiry cycle
      WAIT_DONE: begin
        if (mvm_done) begin
          m_nx     = '0;
          state_nx = CAPTURE;
        end else if (wd == LAST_WD) begin
          err_nx   = 1'b1;
          state_nx = FILL_A;
        end else begin
          wd_nx = wd + 1'b1;
        end
      end
      CAPTURE: begin
        cap_en = 1'b1;
        if (m == LAST_Y) begin
          m_nx     = '0;
          state_nx = DRAIN;
        end else begin
          m_nx = m + 1'b1;
        end
      end
      DRAIN: begin
        if (host.out_ready) begin
          if (m == LAST_Y) begin
            m_nx     = '0;
            state_nx = FILL_A;
          end else begin
            m_nx = m + 1'b1;
          end
        end
      end
      default: state_nx = FILL_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FILL_A;
      active <= 1'b0;
      n      <= '0;
      m      <= '0;
      wd     <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      active <= 1'b1;
      n      <= n_nx;
      m      <= m_nx;
      wd     <= wd_nx;
      err    <= err_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_en) r[m_idx] <= mvm_y;
  end

  mvm_host_buf #(
    .B    (B),
    .DEPTH(K * K),
    .AW   (LOG_BUF)
  ) u_buf (
    .clk  (clk),
    .we   (buf_we),
    .addr (buf_addr),
    .wdata(host.in_data),
    .rdata(buf_rdata)
  );

endmodule

// File: tb/tb_mvm_host_driver.sv
// Directed bench for mvm_host_driver with a cycle-accurate engine model and result scoreboard.
module tb_mvm_host_driver;

  localparam int K       = 4;
  localparam int B       = 8;
  localparam int KK      = K * K;
  localparam int TIMEOUT = 64;

  typedef logic signed [B-1:0] mat_t [KK];
  typedef logic signed [B-1:0] vec_t [K];

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  err;
  logic                  mvm_load_matrix;
  logic                  mvm_load_vector;
  logic                  mvm_start;
  logic signed [B-1:0]   mvm_data;
  logic                  mvm_done;
  logic signed [2*B-1:0] mvm_y;

  int checks   = 0;
  int failures = 0;
  logic signed [2*B-1:0] exp_q [$];

  int eng_lat  = 3;
  bit eng_hang = 1'b0;
  logic signed [B-1:0]   ea [KK];
  logic signed [B-1:0]   ex [K];
  logic signed [2*B-1:0] ey [K];

  mvm_host_if #(.B(B)) host ();

  mvm_host_driver #(.K(K), .B(B), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .host           (host),
    .err            (err),
    .mvm_load_matrix(mvm_load_matrix),
    .mvm_load_vector(mvm_load_vector),
    .mvm_start      (mvm_start),
    .mvm_data       (mvm_data),
    .mvm_done       (mvm_done),
    .mvm_y          (mvm_y)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, host.in_ready, 0);
    chk({tag, "_out_valid"}, host.out_valid, 0);
    chk({tag, "_out_last"}, host.out_last, 0);
    chk({tag, "_out_data"}, host.out_data, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_load_matrix"}, mvm_load_matrix, 0);
    chk({tag, "_load_vector"}, mvm_load_vector, 0);
    chk({tag, "_start"}, mvm_start, 0);
    chk({tag, "_mvm_data"}, mvm_data, 0);
  endtask

  // Engine: samples its inputs at the edge, drives done/y just after it.
  // It captures fixed windows after each load pulse, so a gap corrupts y.
  initial begin : engine
    int ph, cnt, dcnt, yi;
    logic d_nx;
    logic signed [2*B-1:0] y_nx;
    ph = 0; cnt = 0; dcnt = 0; yi = K;
    mvm_done = 1'b0;
    mvm_y    = 16'sh5A5A;
    forever begin
      @(posedge clk);
      d_nx = 1'b0;
      y_nx = 16'sh5A5A;
      if (ph == 1) begin
        ea[cnt] = mvm_data; cnt++;
        if (cnt == KK) ph = 0;
      end else if (ph == 2) begin
        ex[cnt] = mvm_data; cnt++;
        if (cnt == K) ph = 0;
      end
      if (mvm_load_matrix) begin ph = 1; cnt = 0; end
      if (mvm_load_vector) begin ph = 2; cnt = 0; end
      if (mvm_start && !eng_hang) begin
        for (int i = 0; i < K; i++) begin
          ey[i] = '0;
          for (int j = 0; j < K; j++) ey[i] = ey[i] + ea[i*K+j] * ex[j];
        end
        dcnt = eng_lat;
      end
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin d_nx = 1'b1; yi = 0; end
      end else if (yi < K) begin
        y_nx = ey[yi];
        yi++;
      end
      if (reset) begin ph = 0; dcnt = 0; yi = K; d_nx = 1'b0; end
      #1;
      mvm_done = d_nx;
      mvm_y    = y_nx;
    end
  end

  task automatic send_elem(input logic signed [B-1:0] d, input bit gaps);
    int w, g;
    if (gaps) begin
      g = $urandom_range(0, 2);
      host.in_valid = 1'b0;
      repeat (g) step();
    end
    host.in_data  = d;
    host.in_valid = 1'b1;
    w = 0;
    while (!host.in_ready && w < 300) begin step(); w++; end
    if (!host.in_ready) chk("in_accept_timeout", host.in_ready, 1);
    else step();
  endtask

  task automatic send_job(input mat_t a, input vec_t x, input bit gaps,
                          input bit timing, input bit expect_y);
    logic signed [2*B-1:0] y;
    if (expect_y) begin
      for (int i = 0; i < K; i++) begin
        y = '0;
        for (int j = 0; j < K; j++) y = y + a[i*K+j] * x[j];
        exp_q.push_back(y);
      end
    end
    for (int i = 0; i < KK; i++) send_elem(a[i], gaps);
    if (timing) begin
      // x[0] held valid through LOAD_A/SEND_A must not be taken early
      host.in_data  = x[0];
      host.in_valid = 1'b1;
      chk("load_matrix_pulse", mvm_load_matrix, 1);
      chk("load_a_mvm_data", mvm_data, 0);
      chk("load_a_in_ready", host.in_ready, 0);
      step();
      for (int i = 0; i < KK; i++) begin
        chk($sformatf("a_burst_%0d", i), mvm_data, a[i]);
        chk("send_a_in_ready", host.in_ready, 0);
        chk("send_a_load_matrix", mvm_load_matrix, 0);
        step();
      end
      chk("fill_x_ready", host.in_ready, 1);
    end
    for (int j = 0; j < K; j++) send_elem(x[j], gaps);
    host.in_valid = 1'b0;
    if (timing) begin
      chk("load_vector_pulse", mvm_load_vector, 1);
      step();
      for (int j = 0; j < K; j++) begin
        chk($sformatf("x_burst_%0d", j), mvm_data, x[j]);
        chk("send_x_load_vector", mvm_load_vector, 0);
        step();
      end
      chk("start_pulse", mvm_start, 1);
      chk("start_mvm_data", mvm_data, 0);
      step();
      chk("start_one_cycle", mvm_start, 0);
      chk("wait_in_ready", host.in_ready, 0);
      repeat (6) step();
      chk("out_valid_before_rise", host.out_valid, 0);
      step();
      chk("out_valid_rise", host.out_valid, 1);
    end
  endtask

  task automatic drain_job(input int hold);
    int w, bad;
    logic signed [2*B-1:0] e;
    w = 0; bad = 0;
    host.out_ready = (hold == 0);
    while (!host.out_valid && w < TIMEOUT + 200) begin
      if (host.in_ready) bad++;
      step(); w++;
    end
    chk("in_ready_low_while_busy", bad, 0);
    chk("out_valid_seen", host.out_valid, 1);
    e = (exp_q.size() > 0) ? exp_q[0] : '0;
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", host.out_valid, 1);
      chk("hold_data", host.out_data, e);
      chk("hold_last", host.out_last, 0);
      step();
    end
    host.out_ready = 1'b1;
    for (int i = 0; i < K; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk($sformatf("out_valid_%0d", i), host.out_valid, 1);
      chk($sformatf("out_data_%0d", i), host.out_data, e);
      chk($sformatf("out_last_%0d", i), host.out_last, (i == K - 1));
      step();
    end
    host.out_ready = 1'b0;
    chk("idle_after_drain", host.out_valid, 0);
    chk("ready_after_drain", host.in_ready, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    mat_t a_id, a_two, a_r;
    vec_t x1, xm, xr;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        a_id[i*K+j]  = (i == j) ? 8'sd1 : 8'sd0;
        a_two[i*K+j] = 8'sd2;
      end
      x1[i] = B'(i + 1);
      xm[i] = -8'sd1;
      xr[i] = B'($urandom_range(0, 255));
    end
    for (int i = 0; i < KK; i++) a_r[i] = B'($urandom_range(0, 255));

    reset          = 1'b1;
    host.in_valid  = 1'b0;
    host.in_data   = '0;
    host.out_ready = 1'b0;
    repeat (3) step();
    chk_reset_vals("por");
    reset = 1'b0;
    chk("in_ready_at_release", host.in_ready, 0);
    step();
    chk("in_ready_after_release", host.in_ready, 1);

    // identity matrix, gapless, full burst timing
    send_job(a_id, x1, 1'b0, 1'b1, 1'b1);
    drain_job(0);

    // sign handling: every y = -8
    send_job(a_two, xm, 1'b0, 1'b0, 1'b1);
    drain_job(0);

    // bubbles on the input stream
    send_job(a_id, x1, 1'b1, 1'b0, 1'b1);
    drain_job(0);
    send_job(a_r, xr, 1'b1, 1'b0, 1'b1);
    drain_job(0);

    // output backpressure, then a following job
    send_job(a_r, x1, 1'b0, 1'b0, 1'b1);
    drain_job(10);
    send_job(a_two, x1, 1'b0, 1'b0, 1'b1);
    drain_job(0);

    // done lands on the last watchdog cycle
    eng_lat = TIMEOUT;
    send_job(a_id, xm, 1'b0, 1'b0, 1'b1);
    drain_job(0);
    chk("err_done_at_expiry", err, 0);
    eng_lat = 3;

    // engine never answers
    eng_hang = 1'b1;
    send_job(a_two, x1, 1'b0, 1'b0, 1'b0);
    repeat (K + 1) step();
    chk("hang_start", mvm_start, 1);
    repeat (TIMEOUT) step();
    chk("err_before_expiry", err, 0);
    chk("in_ready_before_expiry", host.in_ready, 0);
    step();
    chk("err_at_expiry", err, 1);
    chk("fill_a_after_timeout", host.in_ready, 1);
    chk("no_out_after_timeout", host.out_valid, 0);
    repeat (5) step();
    chk("err_sticky", err, 1);
    eng_hang = 1'b0;

    // reset while a[7] is on mvm_data
    for (int i = 0; i < KK; i++) send_elem(a_r[i], 1'b0);
    host.in_valid = 1'b0;
    chk("err_sticky_next_job", err, 1);
    chk("reset_job_load", mvm_load_matrix, 1);
    repeat (8) step();
    chk("reset_job_a7", mvm_data, a_r[7]);
    reset = 1'b1;
    step();
    chk_reset_vals("midjob");
    reset = 1'b0;
    chk("in_ready_at_release2", host.in_ready, 0);
    step();
    chk("in_ready_after_release2", host.in_ready, 1);

    send_job(a_r, xr, 1'b0, 1'b1, 1'b1);
    drain_job(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mvm_host_driver.md
# mvm_host_driver

Host-side sequencer for the `mvm_<k>_<p>_<b>_<g>` matrix-vector engine; it is the initiator of the engine's load/start/done protocol. It accepts one job over a valid/ready input stream: K·K matrix elements in row-major order, then K vector elements. It replays the job into the engine as gapless load bursts, pulses start, and collects the K results after done. The results are presented on a valid/ready output stream with an end-of-job marker.

## Interface
- K, 16, vector length; the matrix is K×K.
- B, 8, element width; results are 2·B wide.
- TIMEOUT, 1024, maximum cycles to wait for done after start.
- LOG_BUF, $clog2(K·K), staging-buffer address width.
- LOG_K, $clog2(K)+1, result-counter width.

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset; shares its net with the engine reset
- in_valid  in  1  input element valid
- in_ready  out  1  driver accepts an input element
- in_data  in  B  signed element, matrix row-major then vector
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts a result
- out_data  out  2·B  signed result y[i]
- out_last  out  1  high with y[K-1]
- err  out  1  sticky done-timeout flag, cleared only by reset
- mvm_load_matrix  out  1  one-cycle load-matrix pulse to the engine
- mvm_load_vector  out  1  one-cycle load-vector pulse
- mvm_start  out  1  one-cycle start pulse
- mvm_data  out  B  element stream to the engine data_in
- mvm_done  in  1  engine done pulse
- mvm_y  in  2·B  engine data_out

## Operation
- States: FILL_A → LOAD_A → SEND_A → FILL_X → LOAD_X → SEND_X → START → WAIT_DONE → CAPTURE → DRAIN → FILL_A.
- FILL_A: in_ready=1. Each transfer writes buf[n]; n counts 0..K·K-1. After transfer K·K-1, go to LOAD_A.
- LOAD_A: mvm_load_matrix=1 for exactly one cycle, then SEND_A.
- SEND_A: mvm_data presents buf[0..K·K-1], one element per cycle, with no gaps.
- FILL_X: the same staging buffer is reused at addresses 0..K-1.
- LOAD_X and SEND_X mirror LOAD_A and SEND_A, with K elements.
- START: mvm_start=1 for one cycle.
- WAIT_DONE: the watchdog counts cycles.
  - If mvm_done arrives, go to CAPTURE.
  - If the count reaches TIMEOUT, set err=1, drop the job and return to FILL_A.
- CAPTURE: store mvm_y into result buffer r[0..K-1], one per cycle. No backpressure is possible toward the engine.
- DRAIN: out_valid=1 with out_data=r[m]. m advances on out_valid&&out_ready. out_last=1 when m=K-1. After the last beat is accepted, return to FILL_A.
- in_ready=0 in every state except FILL_A and FILL_X. Input is never dropped and never accepted outside a fill.
- mvm_done is ignored outside WAIT_DONE.
- mvm_data=0 whenever not in SEND_A or SEND_X.
- Results are captured verbatim (2·B signed); there is no arithmetic in the driver.

## Timing
- Reset values:
  - in_ready=0, out_valid=0, out_last=0, out_data=0, err=0.
  - All mvm_* outputs = 0.
  - State = FILL_A; in_ready rises the cycle after reset deasserts.
- Reset mid-job: the job is discarded, buffer contents are don't-care, and all outputs return to reset values the next cycle.
- Matrix load: last FILL_A transfer in cycle F → mvm_load_matrix high in F+1 → mvm_data=a[i] in cycle F+2+i, for i=0..K·K-1.
- Vector load: last FILL_X transfer in cycle G → mvm_load_vector high in G+1 → mvm_data=x[j] in G+2+j → mvm_start high in G+2+K.
- FILL_X begins (in_ready=1) the cycle after the last a element.
- The watchdog counts from G+3+K. A timeout fires on cycle G+3+K+TIMEOUT if done has not been seen.
- Result capture: mvm_done high in cycle D → mvm_y sampled as y[i] in cycle D+1+i → out_valid rises in D+K+1.
- DRAIN: out_data and out_last stay stable while out_valid && !out_ready. With out_ready held high, one result is accepted per cycle.
- Staging buffer: registered read, 1-cycle latency. The read address leads mvm_data by one cycle so SEND bursts stay gapless.
- Simultaneous events:
  - in_valid during LOAD or SEND: not accepted.
  - mvm_done in the same cycle the watchdog expires: done wins and the job proceeds.

## Structure
- Package `mvm_host_pkg` holds:
  - the state enum `mvm_host_state_t`;
  - the widths derived from K and B;
  - the default TIMEOUT constant.
- Sub-module `mvm_host_buf`: single-port RAM of width B and depth K·K, with registered read and write-enable, matching the engine's memory style.
- The K-entry result buffer is a flop array inside the top module.
- Total RTL is about 200 lines.

## Test plan
All scenarios use K=4, B=8 with a cycle-accurate engine model.
- Identity matrix, x=1,2,3,4, out_ready=1 → out_data=1,2,3,4; out_last only on the 4th beat; load pulses are one cycle; the a and x bursts are gapless at the cycle offsets above.
- A=all 2s, x=−1,−1,−1,−1 → every y = −8 (0xFFF8). Checks sign handling across the full 2·B width.
- in_valid toggled randomly during both fills → same results as the gapless case; no element lost or duplicated; in_ready=0 during LOAD, SEND and WAIT_DONE.
- out_ready held low for 10 cycles after out_valid rises → out_data=y[0] stays stable; all four results are then delivered in order; the next job then proceeds correctly.
- Engine model never asserts done → err=1 exactly TIMEOUT cycles after WAIT_DONE entry; state returns to FILL_A; err stays 1 until reset.
- reset asserted mid-SEND_A (at element 7) → next cycle all outputs are at reset values; a following full job produces correct results.
